// File: rtl/sqrt_iter.sv
// Sequential integer square root: one root bit per clock, restoring digit-by-digit method.
// Returns floor root and remainder, with optional round-to-nearest and saturation.
module sqrt_iter #(
    parameter int WIDTH = 8,
    localparam int ROOT_W = (WIDTH + 1) / 2
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              start,
    input  logic              round_en,
    input  logic [WIDTH-1:0]  num,
    output logic [ROOT_W-1:0] result,
    output logic [ROOT_W:0]   remainder,
    output logic              sat,
    output logic              busy,
    output logic              ready
);

    localparam int RAD_W = 2 * ROOT_W;
    localparam int REM_W = ROOT_W + 1;
    localparam int CAND_W = ROOT_W + 3;
    localparam int CNT_W = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state, next_state;
    logic [RAD_W-1:0]  rad;
    logic [ROOT_W-1:0] root;
    logic [REM_W-1:0]  rem;
    logic [CNT_W-1:0]  cnt;
    logic              round_q;

    logic              accept;
    logic [CAND_W-1:0] cand, trial, diff;
    logic              ge;
    logic [ROOT_W-1:0] root_next;
    logic [REM_W-1:0]  rem_next;

    assign accept = (state != CALC) && start;
    assign busy   = (state == CALC);
    assign ready  = (state == DONE);

    // One restoring step: bring down the next two radicand bits and try (root<<2)|1.
    assign cand      = {rem, rad[RAD_W-1 -: 2]};
    assign trial     = CAND_W'({root, 2'b01});
    assign ge        = (cand >= trial);
    assign diff      = ge ? (cand - trial) : cand;
    assign rem_next  = REM_W'(diff);
    assign root_next = ROOT_W'({root, ge});

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) state <= IDLE;
        else          state <= next_state;
    end

    // NOTE: next_state gets a default first so no path through the case can infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE: if (start) next_state = CALC;
            CALC:       if (cnt == '0) next_state = DONE;
            default:    next_state = IDLE;
        endcase
    end

    // NOTE: every datapath register is reset, so an abort mid-calculation leaves no stale partial state.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            rad       <= '0;
            root      <= '0;
            rem       <= '0;
            cnt       <= '0;
            round_q   <= 1'b0;
            result    <= '0;
            remainder <= '0;
            sat       <= 1'b0;
        end else if (accept) begin
            rad     <= RAD_W'(num);
            root    <= '0;
            rem     <= '0;
            cnt     <= CNT_W'(ROOT_W - 1);
            round_q <= round_en;
        end else if (state == CALC) begin
            rad  <= rad << 2;
            root <= root_next;
            rem  <= rem_next;
            cnt  <= cnt - CNT_W'(1);
            if (cnt == '0) begin
                remainder <= rem_next;
                // Remainder equal to the root is n = r^2 + r, which lies below the midpoint.
                if (round_q && (rem_next > {1'b0, root_next})) begin
                    if (&root_next) begin
                        result <= root_next;
                        sat    <= 1'b1;
                    end else begin
                        result <= root_next + ROOT_W'(1);
                        sat    <= 1'b0;
                    end
                end else begin
                    result <= root_next;
                    sat    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_sqrt_iter.sv
// Scoreboard bench for sqrt_iter: stimulus pushes model results, a monitor pops on each ready rise.
// Extra instances cover WIDTH=16 and WIDTH=7.
module tb_sqrt_iter;

    localparam int RW = 4;

    logic clk = 1'b0;
    logic clear_n = 1'b0;
    always #5 clk = ~clk;

    logic       start = 1'b0, round_en = 1'b0;
    logic [7:0] num = '0;
    logic [3:0] result;
    logic [4:0] remainder;
    logic       sat, busy, ready;

    logic        s16 = 1'b0, rd16 = 1'b0;
    logic [15:0] n16 = '0;
    logic [7:0]  r16;
    logic [8:0]  rem16;
    logic        sat16, busy16, rdy16;

    logic        s7 = 1'b0, rd7 = 1'b0;
    logic [6:0]  n7 = '0;
    logic [3:0]  r7;
    logic [4:0]  rem7;
    logic        sat7, busy7, rdy7;

    sqrt_iter #(.WIDTH(8)) dut (
        .clk(clk), .clear_n(clear_n), .start(start), .round_en(round_en), .num(num),
        .result(result), .remainder(remainder), .sat(sat), .busy(busy), .ready(ready));

    sqrt_iter #(.WIDTH(16)) dut16 (
        .clk(clk), .clear_n(clear_n), .start(s16), .round_en(rd16), .num(n16),
        .result(r16), .remainder(rem16), .sat(sat16), .busy(busy16), .ready(rdy16));

    sqrt_iter #(.WIDTH(7)) dut7 (
        .clk(clk), .clear_n(clear_n), .start(s7), .round_en(rd7), .num(n7),
        .result(r7), .remainder(rem7), .sat(sat7), .busy(busy7), .ready(rdy7));

    typedef struct {
        int res;
        int rem;
        bit sat;
        int acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: largest r with r*r <= n, found by plain search.
    function automatic exp_t model(int n, bit rnd, int rw);
        exp_t e;
        int r = 0;
        while ((r + 1) * (r + 1) <= n) r++;
        e.rem = n - r * r;
        e.res = r;
        e.sat = 1'b0;
        e.acc = 0;
        if (rnd && e.rem > r) begin
            if (r == (1 << rw) - 1) e.sat = 1'b1;
            else                    e.res = r + 1;
        end
        return e;
    endfunction

    exp_t mon_e;
    bit   rdy_prev = 1'b0;
    always @(negedge clk) begin
        if (!clear_n) begin
            rdy_prev = 1'b0;
        end else begin
            if (ready && !rdy_prev) begin
                if (q.size() == 0) begin
                    check("unexpected_ready", 1, 0);
                end else begin
                    mon_e = q.pop_front();
                    check("result", result, mon_e.res);
                    check("remainder", remainder, mon_e.rem);
                    check("sat", sat, mon_e.sat);
                    check("latency", cyc - mon_e.acc, RW);
                    check("busy_at_ready", busy, 0);
                end
            end
            rdy_prev = ready;
        end
    end

    // Leaves start high; the caller lowers it with idle() when a gap is wanted.
    task automatic issue(int n, bit r);
        exp_t e;
        int waited = 0;
        @(negedge clk);
        while (busy && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (busy) begin
            check("issue_timeout", 1, 0);
            return;
        end
        start = 1'b1;
        num = n[7:0];
        round_en = r;
        @(posedge clk);
        #1;
        e = model(n, r, RW);
        e.acc = cyc;
        q.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((q.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        check("drain", q.size(), 0);
    endtask

    initial begin
        exp_t e;
        int   acc;
        int   t;

        #12;
        check("rst_result", result, 0);
        check("rst_remainder", remainder, 0);
        check("rst_sat", sat, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", ready, 0);
        @(negedge clk);
        clear_n = 1'b1;

        // Perfect squares, start held high across operations.
        for (int a = 1; a <= 15; a++) issue(a * a, 1'b0);
        idle();
        drain();

        issue(0, 1'b0);
        issue(255, 1'b0);
        issue(20, 1'b1);
        issue(21, 1'b1);
        issue(240, 1'b1);
        issue(241, 1'b1);
        idle();
        drain();

        for (int i = 0; i < 40; i++) begin
            issue(int'($urandom_range(255)), 1'($urandom_range(1)));
            if ($urandom_range(1) == 1) begin
                idle();
                repeat ($urandom_range(3)) @(negedge clk);
            end
        end
        idle();
        drain();

        // Start pulsed during CALC must be ignored.
        issue(100, 1'b0);
        idle();
        @(negedge clk);
        start = 1'b1;
        num = 8'd9;
        @(negedge clk);
        start = 1'b0;
        check("busy_in_calc", busy, 1);
        drain();

        issue(9, 1'b0);
        check("ready_drop", ready, 0);
        check("busy_after_start", busy, 1);
        check("result_held", result, 10);
        idle();
        drain();

        // Asynchronous reset in the middle of a calculation.
        issue(144, 1'b0);
        idle();
        @(posedge clk);
        @(posedge clk);
        #3;
        clear_n = 1'b0;
        #1;
        check("arst_result", result, 0);
        check("arst_remainder", remainder, 0);
        check("arst_sat", sat, 0);
        check("arst_busy", busy, 0);
        check("arst_ready", ready, 0);
        q.delete();
        #20;
        @(negedge clk);
        clear_n = 1'b1;
        issue(49, 1'b0);
        idle();
        drain();

        // WIDTH=16
        @(negedge clk);
        n16 = 16'hFFFF;
        s16 = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        @(negedge clk);
        s16 = 1'b0;
        t = 0;
        while (!rdy16 && t < 50) begin
            @(negedge clk);
            t++;
        end
        e = model(65535, 1'b0, 8);
        check("w16_ready", rdy16, 1);
        check("w16_latency", cyc - acc, 8);
        check("w16_result", r16, e.res);
        check("w16_remainder", rem16, e.rem);
        check("w16_sat", sat16, e.sat);

        // WIDTH=7
        @(negedge clk);
        n7 = 7'd121;
        s7 = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        @(negedge clk);
        s7 = 1'b0;
        t = 0;
        while (!rdy7 && t < 50) begin
            @(negedge clk);
            t++;
        end
        e = model(121, 1'b0, 4);
        check("w7_ready", rdy7, 1);
        check("w7_latency", cyc - acc, 4);
        check("w7_result", r7, e.res);
        check("w7_remainder", rem7, e.rem);
        check("w7_sat", sat7, e.sat);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
